mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM pipeline stage of the 5-stage MIPS core. It consumes the EX/MEM register outputs and resolves the branch decision (PCSrc). It performs the data-memory access against a wait-stated data RAM and stalls upstream while the access is in flight. It then registers the MEM/WB pipeline values consumed by the writeback mux.

Parameters:
MEM_WORDS, 256, data RAM depth in 32-bit words; power of two.
MEM_LATENCY, 2, wait cycles per load/store; 0 means single-cycle access.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wb_ctlout  input  2  WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg
m_ctlout  input  3  M control from EX/MEM; [2]=Branch, [1]=MemRead, [0]=MemWrite
add_result  input  32  branch target from EX/MEM
zero  input  1  ALU zero flag from EX/MEM
alu_result  input  32  ALU result; byte address for loads/stores
rdata2out  input  32  store data
five_bit_muxout  input  5  destination register number
pcsrc  output  1  take-branch select to IF PC mux
branch_target  output  32  PC value used when pcsrc=1
stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
addr_err  output  1  one-cycle pulse: misaligned or illegal access completed
memwb_ctl  output  2  registered WB control
memwb_rdata  output  32  registered load data
memwb_alu  output  32  registered ALU result
memwb_rd  output  5  registered destination register

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, wait counter=0, all registered outputs 0, stall=0, addr_err=0. RAM contents are not reset.
- FSM states: IDLE, WAIT.
- IDLE, no memory op (MemRead=MemWrite=0):
  - Each clock: memwb_ctl<=wb_ctlout, memwb_alu<=alu_result, memwb_rd<=five_bit_muxout, memwb_rdata<=0.
- IDLE, memory op, MEM_LATENCY=0:
  - Access completes in the same cycle.
  - Store commits at the clock edge; load data is registered into memwb_rdata.
  - No stall.
- IDLE, memory op, MEM_LATENCY>0:
  - Latch address, store data, WB ctl, rd and op type.
  - Load counter with MEM_LATENCY-1; go to WAIT.
  - stall is combinational: high in IDLE when a memory op is present and MEM_LATENCY>0, and high throughout WAIT until the final cycle.
  - Net: stall is high for exactly MEM_LATENCY cycles per access.
  - While stalled, the MEM/WB register takes a bubble (memwb_ctl<=0).
- WAIT:
  - Counter decrements each clock.
  - On the cycle the counter reads 0: stall=0, store commits to RAM, load data is captured, MEM/WB latches the latched request, FSM returns to IDLE.
- Write commit rule: a store commits exactly once, only at completion. RAM is never written in any other cycle.
- Addressing: word index = latched address[log2(MEM_WORDS)+1:2]. Upper bits are ignored (wrap-around modulo RAM size).
- Misaligned access (address[1:0]!=0):
  - Store is suppressed; load returns 0.
  - Full latency is still spent.
  - addr_err pulses for the completion cycle.
  - WB ctl passes unchanged.
- Illegal encoding (MemRead=MemWrite=1):
  - Treated as a store.
  - memwb_rdata=0, addr_err pulses at completion.
- Branch:
  - pcsrc = Branch & zero & ~stall, combinational from inputs.
  - branch_target = add_result (pass-through).
  - Branch never has a memory op; it never stalls.
- Reset mid-WAIT: access aborts, no RAM write, FSM=IDLE.
- Inputs are ignored while in WAIT; the request was latched at entry.

Decomposition:
- Shared package mips_pkg holds:
  - control-bit index constants: CTL_REGWRITE=1, CTL_MEMTOREG=0, CTL_BRANCH=2, CTL_MEMREAD=1, CTL_MEMWRITE=0
  - FSM state encoding: IDLE=1'b0, WAIT=1'b1
- One sub-module, data_mem: synchronous write, combinational read, parameter MEM_WORDS, ports clk/we/addr/wdata/rdata.
- FSM, counter, branch logic and MEM/WB register stay in mem_stage.

Test Plan:
1. Reset low mid-operation with outputs nonzero -> all outputs 0 immediately, before next clock; after release, FSM=IDLE, stall=0.
2. MEM_LATENCY=2:
   - Store 0xDEADBEEF to address 0x10 -> stall high 2 cycles, one RAM write to word 4, memwb_ctl=0 during stall.
   - Subsequent load from 0x10 -> memwb_rdata=0xDEADBEEF on completion edge, memwb_rd/ctl match the load.
3. R-type stream, wb_ctlout=2'b10, alu_result=0x55, rd=7 -> MEM/WB shows 2'b10/0x55/7 one clock later, stall never asserts.
4. Branch=1, zero=1, add_result=0x40 -> pcsrc=1, branch_target=0x40 same cycle. Same with zero=0 -> pcsrc=0.
5. Misaligned store to 0x13 with data 0x1234 -> no RAM change (word 4 still 0xDEADBEEF), addr_err pulses one cycle at completion. Repeat with MemRead=MemWrite=1 -> addr_err pulse, memwb_rdata=0.
6. Store to 0x20 aborted by reset on the first WAIT cycle -> word 8 unchanged. Also, address 0x400 with MEM_WORDS=256 wraps to word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, MEM-stage FSM encoding
// and the latched memory request payload.
package mips_pkg;

  localparam int unsigned CTL_REGWRITE = 1;
  localparam int unsigned CTL_MEMTOREG = 0;
  localparam int unsigned CTL_BRANCH   = 2;
  localparam int unsigned CTL_MEMREAD  = 1;
  localparam int unsigned CTL_MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic        rd_op;
    logic        wr_op;
  } mem_req_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM: synchronous write, combinational read, no reset.
module data_mem #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, wait-stated data access
// with upstream stall, and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        addr_err,
  output logic [1:0]  memwb_ctl,
  output logic [31:0] memwb_rdata,
  output logic [31:0] memwb_alu,
  output logic [4:0]  memwb_rd
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         in_req, lat_q, req;
  logic             mem_op_c, latch_c, complete_c, stall_c;
  logic             misalign_c, err_c, we_c;
  logic [31:0]      ram_rdata, load_data_c;

  assign in_req = '{addr:  alu_result,
                    wdata: rdata2out,
                    wb:    wb_ctlout,
                    rd:    five_bit_muxout,
                    rd_op: m_ctlout[CTL_MEMREAD],
                    wr_op: m_ctlout[CTL_MEMWRITE]};

  assign mem_op_c = in_req.rd_op | in_req.wr_op;
  // In WAIT the EX/MEM inputs are frozen/ignored; the request latched at entry is used
  assign req      = (state_q == WAIT) ? lat_q : in_req;

  // Next-state, counter and access-phase decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_c    = 1'b0;
    complete_c = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_c) begin
          if (MEM_LATENCY == 0) begin
            complete_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            latch_c = 1'b1;
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          complete_c = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall         = stall_c & rst_n;
  assign pcsrc         = m_ctlout[CTL_BRANCH] & zero & ~stall;
  assign branch_target = add_result;

  // Illegal read+write encoding behaves as a store but is flagged
  assign misalign_c  = |req.addr[1:0];
  assign err_c       = misalign_c | (req.rd_op & req.wr_op);
  assign we_c        = complete_c & req.wr_op & ~misalign_c & rst_n;
  assign load_data_c = (req.rd_op & ~req.wr_op & ~misalign_c) ? ram_rdata : 32'h0;

  data_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (we_c),
    .addr  (req.addr[AW+1:2]),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      addr_err    <= 1'b0;
      memwb_ctl   <= 2'b00;
      memwb_rdata <= 32'h0;
      memwb_alu   <= 32'h0;
      memwb_rd    <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_err <= complete_c & err_c;
      if (latch_c) lat_q <= in_req;
      if (complete_c) begin
        memwb_ctl   <= req.wb;
        memwb_rdata <= load_data_c;
        memwb_alu   <= req.addr;
        memwb_rd    <= req.rd;
      end else if (stall_c) begin
        memwb_ctl <= 2'b00;
      end else begin
        memwb_ctl   <= wb_ctlout;
        memwb_rdata <= 32'h0;
        memwb_alu   <= alu_result;
        memwb_rd    <= five_bit_muxout;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of predicted MEM/WB results per op,
// plus directed branch, reset-abort and addressing scenarios.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic        addr_err;
  logic [1:0]  memwb_ctl;
  logic [31:0] memwb_rdata;
  logic [31:0] memwb_alu;
  logic [4:0]  memwb_rd;

  mem_stage #(.MEM_WORDS(WORDS), .MEM_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_ctlout       (wb_ctlout),
    .m_ctlout        (m_ctlout),
    .add_result      (add_result),
    .zero            (zero),
    .alu_result      (alu_result),
    .rdata2out       (rdata2out),
    .five_bit_muxout (five_bit_muxout),
    .pcsrc           (pcsrc),
    .branch_target   (branch_target),
    .stall           (stall),
    .addr_err        (addr_err),
    .memwb_ctl       (memwb_ctl),
    .memwb_rdata     (memwb_rdata),
    .memwb_alu       (memwb_alu),
    .memwb_rd        (memwb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ctl;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        err;
    logic [3:0]  stalls;
    logic [1:0]  writes;
    logic        bubble_ctl;
  } res_t;

  res_t        sb[$];
  logic [31:0] model_mem [int];
  int          checks = 0;
  int          passed = 0;
  int          wr_count = 0;

  always @(posedge clk) if (dut.u_mem.we) wr_count++;

  // Reference model of one MEM-stage operation
  function automatic res_t predict(input logic [1:0] wb, input logic [2:0] m,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [4:0] rd);
    res_t e;
    logic is_mem, aligned;
    int   idx;
    e       = '0;
    is_mem  = m[1] | m[0];
    aligned = (addr[1:0] == 2'b00);
    idx     = int'(addr[9:2]);
    e.ctl   = wb;
    e.alu   = addr;
    e.rd    = rd;
    if (is_mem) begin
      e.stalls = 4'(LAT);
      e.err    = !aligned || (m[1] && m[0]);
      if (m[0]) begin
        if (aligned) begin
          model_mem[idx] = wdata;
          e.writes = 2'd1;
        end
      end else if (aligned) begin
        e.rdata = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      end
    end
    return e;
  endfunction

  task automatic drive_nop();
    wb_ctlout = 2'b00; m_ctlout = 3'b000; add_result = 32'h0; zero = 1'b0;
    alu_result = 32'h0; rdata2out = 32'h0; five_bit_muxout = 5'd0;
  endtask

  // Issue one op, push its prediction, follow it to the MEM/WB edge and report what was seen
  task automatic run_op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, output res_t o);
    int wr0;
    bit done;
    @(negedge clk);
    wb_ctlout = wb; m_ctlout = m; alu_result = addr; rdata2out = wdata;
    five_bit_muxout = rd; zero = 1'b0; add_result = 32'h0;
    sb.push_back(predict(wb, m, addr, wdata, rd));
    o    = '0;
    wr0  = wr_count;
    done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      o.stalls = o.stalls + 4'd1;
      if (i > 0) o.bubble_ctl = o.bubble_ctl | (|memwb_ctl);
      @(negedge clk);
    end
    if (!done) o.stalls = 4'hF;
    @(posedge clk);
    #1;
    o.ctl    = memwb_ctl;
    o.rdata  = memwb_rdata;
    o.alu    = memwb_alu;
    o.rd     = memwb_rd;
    o.err    = addr_err;
    o.writes = 2'(wr_count - wr0);
  endtask

  task automatic test_reset();
    res_t        o, e;
    logic [73:0] outs;
    int          w0;
    drive_nop();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {stall, addr_err, memwb_ctl, memwb_rdata, memwb_alu, memwb_rd, pcsrc};
    checks++;
    if (outs !== '0) $display("FAIL por_outputs got %h exp 0", outs); else passed++;
    @(negedge clk) rst_n = 1'b1;

    run_op(2'b00, 3'b001, 32'h20, 32'hA5A5_A5A5, 5'd0, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL seed_store got %h exp %h", o, e); else passed++;
    run_op(2'b10, 3'b000, 32'h77, 32'h0, 5'd9, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL pre_reset_rtype got %h exp %h", o, e); else passed++;

    @(negedge clk);
    wb_ctlout = 2'b00; m_ctlout = 3'b001; alu_result = 32'h20;
    rdata2out = 32'h1111_1111; five_bit_muxout = 5'd2;
    w0 = wr_count;
    @(posedge clk);
    #2;
    checks++;
    if (stall !== 1'b1) $display("FAIL abort_in_wait got stall=%b exp 1", stall); else passed++;
    rst_n = 1'b0;
    #1;
    outs = {stall, addr_err, memwb_ctl, memwb_rdata, memwb_alu, memwb_rd, 1'b0};
    checks++;
    if (outs !== '0) $display("FAIL reset_async got %h exp 0", outs); else passed++;
    @(negedge clk) drive_nop();
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL reset_release got stall=%b exp 0", stall); else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (dut.state_q !== IDLE || stall !== 1'b0 || wr_count != w0)
      $display("FAIL post_reset got state=%b stall=%b writes=%0d exp IDLE/0/0",
               dut.state_q, stall, wr_count - w0);
    else passed++;

    run_op(2'b11, 3'b010, 32'h20, 32'h0, 5'd4, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL abort_word8 got %h exp %h", o, e); else passed++;
  endtask

  task automatic test_rtype();
    res_t        o, e;
    logic [1:0]  ctl_t [3] = '{2'b10, 2'b11, 2'b00};
    logic [31:0] alu_t [3] = '{32'h55, 32'hFFFF_0000, 32'h1};
    logic [4:0]  rd_t  [3] = '{5'd7, 5'd31, 5'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(ctl_t[i], 3'b000, alu_t[i], 32'hBAD0_0000, rd_t[i], o);
      e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL rtype_%0d got %h exp %h", i, o, e); else passed++;
    end
  endtask

  task automatic test_store_load();
    res_t o, e;
    run_op(2'b00, 3'b001, 32'h10, 32'hDEAD_BEEF, 5'd0, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL store_0x10 got %h exp %h", o, e); else passed++;
    checks++;
    if (dut.u_mem.mem[4] !== 32'hDEAD_BEEF)
      $display("FAIL store_word4 got %h exp deadbeef", dut.u_mem.mem[4]);
    else passed++;
    run_op(2'b11, 3'b010, 32'h10, 32'h0, 5'd5, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL load_0x10 got %h exp %h", o, e); else passed++;
  endtask

  task automatic test_branch();
    logic [33:0] got, exp;
    logic [2:0]  m_t  [4] = '{3'b100, 3'b100, 3'b100, 3'b110};
    logic        z_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] a_t  [4] = '{32'h40, 32'h40, 32'h1234_5678, 32'h80};
    logic        p_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive_nop();
    for (int i = 0; i < 4; i++) begin
      m_ctlout = m_t[i]; zero = z_t[i]; add_result = a_t[i];
      #1;
      got = {1'b0, pcsrc, branch_target};
      exp = {1'b0, p_t[i], a_t[i]};
      checks++;
      if (got !== exp) $display("FAIL branch_%0d got %h exp %h", i, got, exp); else passed++;
    end
    drive_nop();
  endtask

  task automatic test_misaligned();
    res_t        o, e;
    logic [1:0]  wb_t [5] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [2:0]  m_t  [5] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b000};
    logic [31:0] a_t  [5] = '{32'h13, 32'h5, 32'h13, 32'h12, 32'h6};
    logic [4:0]  rd_t [5] = '{5'd1, 5'd2, 5'd3, 5'd6, 5'd8};
    for (int i = 0; i < 5; i++) begin
      run_op(wb_t[i], m_t[i], a_t[i], 32'h1234, rd_t[i], o);
      e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL misaligned_%0d got %h exp %h", i, o, e); else passed++;
    end
    checks++;
    if (dut.u_mem.mem[4] !== 32'hDEAD_BEEF)
      $display("FAIL misaligned_word4 got %h exp deadbeef", dut.u_mem.mem[4]);
    else passed++;
  endtask

  task automatic test_wrap();
    res_t o, e;
    run_op(2'b00, 3'b001, 32'h400, 32'hCAFE_F00D, 5'd0, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL wrap_store got %h exp %h", o, e); else passed++;
    checks++;
    if (dut.u_mem.mem[0] !== 32'hCAFE_F00D)
      $display("FAIL wrap_word0 got %h exp cafef00d", dut.u_mem.mem[0]);
    else passed++;
    run_op(2'b11, 3'b010, 32'h0, 32'h0, 5'd10, o);
    e = sb.pop_front(); checks++;
    if (o !== e) $display("FAIL wrap_load got %h exp %h", o, e); else passed++;
  endtask

  task automatic test_back_to_back();
    res_t        o, e;
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h40 + 32'(4 * (i % 4));
      if (i < 4)
        run_op(2'b00, 3'b001, addr, $urandom, 5'(i), o);
      else
        run_op(2'b11, 3'b010, addr, 32'h0, 5'(i + 16), o);
      e = sb.pop_front(); checks++;
      if (o !== e) $display("FAIL b2b_%0d got %h exp %h", i, o, e); else passed++;
    end
  endtask

  initial begin
    drive_nop();
    rst_n = 1'b0;
    test_reset();
    test_rtype();
    test_store_load();
    test_branch();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
